i2s_frame_scheduler: RTL

//  Sequences one frame of deserialised I2S samples (all channels, one sample_valid event)

---
 rtl/i2s_frame_scheduler.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/i2s_frame_scheduler.sv
// rtl/i2s_frame_scheduler.sv - issues one I2S frame per channel into a shared DSP lane
// Active + pending frame buffers; each frame carries its own snapshot of the channel mask.
module i2s_frame_scheduler #(
  parameter int I2S_WIDTH          = 24,
  parameter int NUM_AUDIO_CHANNELS = 4,
  parameter int OVR_CNT_WIDTH      = 8,
  localparam int CH_W = (NUM_AUDIO_CHANNELS > 1) ? $clog2(NUM_AUDIO_CHANNELS) : 1
) (
  input  logic                                    sys_clk,
  input  logic                                    sys_rst_n,
  input  logic                                    enable,
  input  logic [NUM_AUDIO_CHANNELS-1:0]           ch_mask,
  input  logic                                    frame_valid,
  input  logic [NUM_AUDIO_CHANNELS*I2S_WIDTH-1:0] frame_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [I2S_WIDTH-1:0]                    out_data,
  output logic [CH_W-1:0]                         out_chan,
  output logic                                    out_last,
  output logic                                    frame_done,
  output logic                                    busy,
  output logic                                    overrun,
  output logic [OVR_CNT_WIDTH-1:0]                overrun_cnt
);

  localparam int N  = NUM_AUDIO_CHANNELS;
  localparam int DW = NUM_AUDIO_CHANNELS * I2S_WIDTH;

  typedef enum logic {S_IDLE, S_ISSUE} state_e;

  state_e                   state_q, state_d;
  logic [DW-1:0]            act_data_q, act_data_d;
  logic [N-1:0]             rem_q, rem_d;
  logic                     pend_valid_q, pend_valid_d;
  logic [DW-1:0]            pend_data_q, pend_data_d;
  logic [N-1:0]             pend_mask_q, pend_mask_d;
  logic                     out_valid_q, out_valid_d;
  logic [I2S_WIDTH-1:0]     out_data_q, out_data_d;
  logic [CH_W-1:0]          out_chan_q, out_chan_d;
  logic                     out_last_q, out_last_d;
  logic                     frame_done_q, frame_done_d;
  logic                     busy_q, busy_d;
  logic                     overrun_q, overrun_d;
  logic [OVR_CNT_WIDTH-1:0] ovr_cnt_q, ovr_cnt_d;

  logic         accept;
  logic         xfer;
  logic         active_done;
  logic [N-1:0] rem_after;

  function automatic logic [CH_W-1:0] lowest_idx(input logic [N-1:0] m);
    lowest_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = CH_W'(i);
    end
  endfunction

  always_comb begin
    accept    = frame_valid & enable;
    xfer      = out_valid_q & out_ready;
    // rem_q holds the enabled channels of the active frame not yet transferred
    rem_after = xfer ? (rem_q & (rem_q - N'(1))) : rem_q;
    active_done = (state_q == S_ISSUE) && (rem_after == '0);

    state_d      = state_q;
    act_data_d   = act_data_q;
    rem_d        = rem_after;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    pend_mask_d  = pend_mask_q;
    frame_done_d = active_done;
    overrun_d    = 1'b0;
    ovr_cnt_d    = ovr_cnt_q;

    if (state_q == S_IDLE) begin
      if (accept) begin
        state_d    = S_ISSUE;
        act_data_d = frame_data;
        rem_d      = ch_mask;
      end
    end else if (active_done) begin
      if (pend_valid_q) begin
        act_data_d   = pend_data_q;
        rem_d        = pend_mask_q;
        pend_valid_d = accept;
        if (accept) begin
          pend_data_d = frame_data;
          pend_mask_d = ch_mask;
        end
      end else if (accept) begin
        act_data_d = frame_data;
        rem_d      = ch_mask;
      end else begin
        state_d = S_IDLE;
      end
    end else if (accept) begin
      if (!pend_valid_q) begin
        pend_valid_d = 1'b1;
        pend_data_d  = frame_data;
        pend_mask_d  = ch_mask;
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (overrun_d && (ovr_cnt_q != '1)) ovr_cnt_d = ovr_cnt_q + OVR_CNT_WIDTH'(1);

    // Outputs are registered from next state, so they stay put while stalled
    out_valid_d = (state_d == S_ISSUE) && (rem_d != '0);
    out_chan_d  = lowest_idx(rem_d);
    out_data_d  = act_data_d[out_chan_d*I2S_WIDTH +: I2S_WIDTH];
    out_last_d  = (rem_d != '0) && ((rem_d & (rem_d - N'(1))) == '0);
    busy_d      = (state_d == S_ISSUE) || pend_valid_d;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_IDLE;
      act_data_q   <= '0;
      rem_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      pend_mask_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_chan_q   <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      ovr_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      act_data_q   <= act_data_d;
      rem_q        <= rem_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      pend_mask_q  <= pend_mask_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_chan_q   <= out_chan_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      ovr_cnt_q    <= ovr_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_chan    = out_chan_q;
  assign out_last    = out_last_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign overrun_cnt = ovr_cnt_q;

endmodule
